// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access sizes, FSM states, timeout default.
package mem_stage_pkg;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        SZ_WORD  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_WORD3 = 2'b11   // reserved encoding, behaves as word
    } mem_size_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_e;
endpackage

// File: rtl/memory_stage_load_align.sv
// Load lane extraction: picks the addressed byte/half out of a little-endian
// word and zero- or sign-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Size-dependent extension; word (and the reserved code) pass through.
    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: single outstanding memory access with ack handshake,
// alignment check, timeout abort and registered writeback outputs.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int ADDR_W         = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [31:0]       WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic [4:0]        RegDestSelected,
    input  logic              RegWrite,
    input  logic              MemToReg,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemByteEn,
    input  logic [31:0]       MemRData,
    input  logic              MemAck,
    output logic              OutValid,
    output logic [31:0]       WB_Data,
    output logic [4:0]        WB_RegDest,
    output logic              WB_RegWrite,
    output logic              Misaligned,
    output logic              BusError
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_signed;
    logic             r_load;
    logic             r_memtoreg;
    logic [31:0]      r_alu;
    logic [4:0]       r_rd;
    logic             r_regwrite;

    logic        w_is_mem;
    logic        w_is_word;
    logic        w_misaligned;
    logic [31:0] w_alu32;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_ld;

    assign Stall        = (r_state == ST_WAIT_ACK);
    assign w_is_mem     = MemRead | MemWrite;
    assign w_is_word    = (MemSize == SZ_WORD) || (MemSize == SZ_WORD3);
    assign w_misaligned = ((MemSize == SZ_HALF) && ALUResult[0]) ||
                          (w_is_word && (ALUResult[1:0] != 2'b00));
    assign w_alu32      = 32'(ALUResult);

    // Store lane steering; loads always fetch the full word.
    always_comb begin
        w_wdata = WriteData;
        w_be    = 4'b1111;
        if (MemWrite) begin
            case (MemSize)
                SZ_BYTE: begin
                    w_wdata = {4{WriteData[7:0]}};
                    w_be    = 4'b0001 << ALUResult[1:0];
                end
                SZ_HALF: begin
                    w_wdata = {2{WriteData[15:0]}};
                    w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = WriteData;
                    w_be    = 4'b1111;
                end
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata  (MemRData),
        .i_lane   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ld)
    );

    // Control FSM with all bus and writeback outputs registered.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_load      <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alu       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            MemByteEn   <= '0;
            OutValid    <= 1'b0;
            WB_Data     <= '0;
            WB_RegDest  <= '0;
            WB_RegWrite <= 1'b0;
            Misaligned  <= 1'b0;
            BusError    <= 1'b0;
        end else begin
            OutValid   <= 1'b0;
            Misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        if (!w_is_mem) begin
                            OutValid    <= 1'b1;
                            WB_Data     <= w_alu32;
                            WB_RegDest  <= RegDestSelected;
                            WB_RegWrite <= RegWrite;
                        end else if (w_misaligned) begin
                            Misaligned  <= 1'b1;
                            OutValid    <= 1'b1;
                            WB_Data     <= w_alu32;
                            WB_RegDest  <= RegDestSelected;
                            WB_RegWrite <= 1'b0;
                        end else begin
                            r_state    <= ST_WAIT_ACK;
                            r_cnt      <= '0;
                            MemReq     <= 1'b1;
                            MemWe      <= MemWrite;   // both set resolves to store
                            MemAddr    <= {ALUResult[ADDR_W-1:2], 2'b00};
                            MemWData   <= w_wdata;
                            MemByteEn  <= w_be;
                            r_lane     <= ALUResult[1:0];
                            r_size     <= MemSize;
                            r_signed   <= MemSigned;
                            r_load     <= ~MemWrite;
                            r_memtoreg <= MemToReg;
                            r_alu      <= w_alu32;
                            r_rd       <= RegDestSelected;
                            r_regwrite <= RegWrite;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (MemAck) begin
                        // Ack takes priority over a coincident timeout.
                        r_state     <= ST_IDLE;
                        MemReq      <= 1'b0;
                        OutValid    <= 1'b1;
                        WB_RegWrite <= r_regwrite;
                        WB_RegDest  <= r_rd;
                        WB_Data     <= (r_load && r_memtoreg) ? w_ld : r_alu;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_IDLE;
                        MemReq      <= 1'b0;
                        BusError    <= 1'b1;
                        OutValid    <= 1'b1;
                        WB_RegWrite <= 1'b0;
                        WB_RegDest  <= r_rd;
                        WB_Data     <= r_alu;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed checks for memory_stage: ALU pass-through, loads/stores, alignment,
// timeout, ack/timeout collision and mid-access reset.
module tb_memory_stage;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        InValid = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic        MemSigned = 1'b0;
    logic [4:0]  RegDestSelected = '0;
    logic        RegWrite = 1'b0;
    logic        MemToReg = 1'b0;
    logic        Stall, MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRData = '0;
    logic        MemAck = 1'b0;
    logic        OutValid;
    logic [31:0] WB_Data;
    logic [4:0]  WB_RegDest;
    logic        WB_RegWrite, Misaligned, BusError;

    int total = 0;
    int bad   = 0;

    memory_stage #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .ALUResult(ALUResult),
        .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned),
        .RegDestSelected(RegDestSelected), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
        .MemRData(MemRData), .MemAck(MemAck), .OutValid(OutValid),
        .WB_Data(WB_Data), .WB_RegDest(WB_RegDest), .WB_RegWrite(WB_RegWrite),
        .Misaligned(Misaligned), .BusError(BusError)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sgn, input logic [4:0] dst,
                         input logic rw, input logic m2r, input logic [31:0] wd);
        InValid = 1'b1; ALUResult = addr; MemRead = rd; MemWrite = wr;
        MemSize = sz; MemSigned = sgn; RegDestSelected = dst; RegWrite = rw;
        MemToReg = m2r; WriteData = wd;
    endtask

    task automatic idle_in();
        InValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        #3;
        chk("rst_outvalid", 32'(OutValid), 0);
        chk("rst_memreq", 32'(MemReq), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_wbdata", WB_Data, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_buserr", 32'(BusError), 0);
        tick();
        Rst = 1'b1;
        tick();

        // ALU op, 1-cycle latency
        issue(32'd120, 0, 0, 2'b00, 0, 5'd16, 1, 0, 0);
        tick();
        idle_in();
        chk("alu_outvalid", 32'(OutValid), 1);
        chk("alu_wbdata", WB_Data, 32'd120);
        chk("alu_rd", 32'(WB_RegDest), 32'd16);
        chk("alu_rw", 32'(WB_RegWrite), 1);
        chk("alu_stall", 32'(Stall), 0);
        tick();
        chk("alu_ov_drop", 32'(OutValid), 0);
        chk("alu_wb_hold", WB_Data, 32'd120);

        // signed byte load at 0x103, ack in third wait cycle
        issue(32'h103, 1, 0, 2'b10, 1, 5'd5, 1, 1, 0);
        tick();
        idle_in();
        chk("lb_memreq", 32'(MemReq), 1);
        chk("lb_addr", MemAddr, 32'h100);
        chk("lb_be", 32'(MemByteEn), 32'hF);
        chk("lb_we", 32'(MemWe), 0);
        chk("lb_ov", 32'(OutValid), 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (Stall) n++;
            if (i == 2) begin MemAck = 1'b1; MemRData = 32'h80AABBCC; end
            tick();
        end
        MemAck = 1'b0;
        chk("lb_stall_cycles", n, 3);
        chk("lb_ov", 32'(OutValid), 1);
        chk("lb_data", WB_Data, 32'hFFFFFF80);
        chk("lb_rw", 32'(WB_RegWrite), 1);
        chk("lb_rd", 32'(WB_RegDest), 32'd5);
        chk("lb_stall_after", 32'(Stall), 0);
        chk("lb_req_after", 32'(MemReq), 0);

        // unsigned half load at 0x102, immediate ack
        issue(32'h102, 1, 0, 2'b01, 0, 5'd7, 1, 1, 0);
        tick();
        idle_in();
        MemAck = 1'b1; MemRData = 32'h8001FFFF;
        tick();
        MemAck = 1'b0;
        chk("lhu_data", WB_Data, 32'h00008001);

        // half store at 0x102
        issue(32'h102, 0, 1, 2'b01, 0, 5'd0, 0, 0, 32'h00001234);
        tick();
        idle_in();
        chk("sh_we", 32'(MemWe), 1);
        chk("sh_be", 32'(MemByteEn), 32'hC);
        chk("sh_wdata", MemWData, 32'h12341234);
        chk("sh_addr", MemAddr, 32'h100);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("sh_ov", 32'(OutValid), 1);
        chk("sh_rw", 32'(WB_RegWrite), 0);
        chk("sh_data", WB_Data, 32'h102);

        // byte store at 0x101 with both read and write set -> store
        issue(32'h101, 1, 1, 2'b10, 0, 5'd0, 0, 0, 32'h000000AB);
        tick();
        idle_in();
        chk("sb_we", 32'(MemWe), 1);
        chk("sb_be", 32'(MemByteEn), 32'h2);
        chk("sb_wdata", MemWData, 32'hABABABAB);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;

        // misaligned word load at 0x6
        issue(32'h6, 1, 0, 2'b00, 0, 5'd9, 1, 1, 0);
        tick();
        idle_in();
        chk("mis_req", 32'(MemReq), 0);
        chk("mis_pulse", 32'(Misaligned), 1);
        chk("mis_ov", 32'(OutValid), 1);
        chk("mis_rw", 32'(WB_RegWrite), 0);
        chk("mis_stall", 32'(Stall), 0);
        tick();
        chk("mis_pulse_end", 32'(Misaligned), 0);
        chk("mis_ov_end", 32'(OutValid), 0);

        // ack arriving in the expiry cycle wins
        issue(32'h300, 1, 0, 2'b00, 0, 5'd4, 1, 1, 0);
        tick();
        idle_in();
        for (int i = 0; i < 15; i++) tick();
        chk("col_still_wait", 32'(Stall), 1);
        MemAck = 1'b1; MemRData = 32'hCAFEF00D;
        tick();
        MemAck = 1'b0;
        chk("col_ov", 32'(OutValid), 1);
        chk("col_rw", 32'(WB_RegWrite), 1);
        chk("col_data", WB_Data, 32'hCAFEF00D);
        chk("col_buserr", 32'(BusError), 0);

        // timeout with ack withheld
        issue(32'h200, 1, 0, 2'b00, 0, 5'd6, 1, 1, 0);
        tick();
        idle_in();
        n = 0;
        while (Stall && n < 40) begin
            n++;
            tick();
        end
        chk("to_wait_cycles", n, 16);
        chk("to_buserr", 32'(BusError), 1);
        chk("to_req", 32'(MemReq), 0);
        chk("to_ov", 32'(OutValid), 1);
        chk("to_rw", 32'(WB_RegWrite), 0);
        MemAck = 1'b1; MemRData = 32'h12345678;
        tick();
        MemAck = 1'b0;
        chk("late_ack_ov", 32'(OutValid), 0);
        chk("late_ack_stall", 32'(Stall), 0);
        chk("late_ack_data", WB_Data, 32'h200);

        // reset during WAIT_ACK
        issue(32'h400, 1, 0, 2'b00, 0, 5'd2, 1, 1, 0);
        tick();
        idle_in();
        chk("rw_req_before", 32'(MemReq), 1);
        #2 Rst = 1'b0;
        #1;
        chk("rw_req", 32'(MemReq), 0);
        chk("rw_ov", 32'(OutValid), 0);
        chk("rw_stall", 32'(Stall), 0);
        chk("rw_buserr", 32'(BusError), 0);
        #3 Rst = 1'b1;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("rw_stray_ack", 32'(OutValid), 0);
        issue(32'd77, 0, 0, 2'b00, 0, 5'd3, 1, 0, 0);
        tick();
        idle_in();
        chk("rw_alu_ov", 32'(OutValid), 1);
        chk("rw_alu_data", WB_Data, 32'd77);
        chk("rw_alu_rd", 32'(WB_RegDest), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max cycles waited for MemAck before abort.
REQ-002 Parameter ADDR_W, default 32, width of the address input and MemAddr.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Rst  in  1  asynchronous, active-low reset.
REQ-005 InValid  in  1  the EX/MEM fields below carry an instruction this cycle.
REQ-006 ALUResult  in  ADDR_W  effective address or ALU result.
REQ-007 WriteData  in  32  store data (rt register value).
REQ-008 MemRead, MemWrite  in  1 each  load / store; both high is illegal and is treated as a store.
REQ-009 MemSize  in  2  00 word, 01 half, 10 byte; 11 is treated as word.
REQ-010 MemSigned  in  1  sign-extend sub-word loads.
REQ-011 RegDestSelected  in  5; RegWrite  in  1; MemToReg  in  1  writeback controls.
REQ-012 Stall  out  1  upstream SHALL hold every input while high.
REQ-013 MemReq, MemWe  out  1 each; MemAddr  out  ADDR_W (word-aligned); MemWData  out  32; MemByteEn  out  4.
REQ-014 MemRData  in  32; MemAck  in  1  single-cycle completion pulse.
REQ-015 OutValid  out  1; WB_Data  out  32; WB_RegDest  out  5; WB_RegWrite  out  1  registered outputs to writeback.
REQ-016 Misaligned  out  1  one-cycle pulse; BusError  out  1  sticky flag.

Function
REQ-017 The FSM SHALL have states IDLE and WAIT_ACK; Stall SHALL equal (state == WAIT_ACK), including the cycle MemAck arrives.
REQ-018 In IDLE with InValid high and neither MemRead nor MemWrite set, the next edge SHALL register OutValid=1, WB_Data=ALUResult, WB_RegDest, and WB_RegWrite=RegWrite (1-cycle latency).
REQ-019 In IDLE with InValid high, a memory op, and an aligned address, the next edge SHALL latch address, data, and controls, enter WAIT_ACK, and clear OutValid.
REQ-020 In WAIT_ACK, MemReq SHALL be 1. MemWe, MemAddr={addr[ADDR_W-1:2],2'b00}, MemWData, and MemByteEn SHALL stay constant until exit.
REQ-021 Byte lanes SHALL be little-endian. Byte: MemByteEn=4'b0001<<addr[1:0], data replicated in all lanes. Half: 0011 or 1100 by addr[1], data replicated in both halves. Word: 1111.
REQ-022 Alignment: a half with addr[0]=1 or a word with addr[1:0]!=0 is misaligned. It SHALL issue no MemReq, pulse Misaligned, and register OutValid=1 with WB_RegWrite=0 on the next edge.
REQ-023 On MemAck in WAIT_ACK, the next edge SHALL return to IDLE and register OutValid=1 and WB_RegWrite=latched RegWrite. For a load with MemToReg=1, WB_Data SHALL be the extracted lane, zero- or sign-extended per MemSigned; otherwise WB_Data SHALL be the latched ALUResult.
REQ-024 A wait counter SHALL clear on WAIT_ACK entry and increment each WAIT_ACK cycle. If it reaches TIMEOUT_CYCLES without MemAck, the next edge SHALL return to IDLE, drop MemReq, set BusError, and register OutValid=1 with WB_RegWrite=0.
REQ-025 If MemAck and timeout expiry occur in the same cycle, MemAck SHALL win and BusError SHALL stay unchanged.
REQ-026 MemAck received in IDLE SHALL be ignored.
REQ-027 OutValid SHALL be 0 in any cycle after an edge on which no instruction completed; WB_* SHALL hold their last values.
REQ-028 Instructions SHALL complete in acceptance order; at most one instruction is in flight.

Reset
REQ-029 Rst low SHALL immediately force state=IDLE, counter=0, and MemReq, MemWe, MemByteEn, OutValid, WB_RegWrite, Misaligned, and BusError to 0, and WB_Data, WB_RegDest, MemAddr, and MemWData to 0.
REQ-030 A reset during WAIT_ACK SHALL abandon the access with no output; a later stray MemAck SHALL be ignored per REQ-026.

Structure
REQ-031 Package mem_stage_pkg SHALL hold the MemSize encodings, the FSM state encoding, and the TIMEOUT_CYCLES default.
REQ-032 Sub-module load_align (combinational) SHALL implement lane extraction and zero/sign extension, and SHALL be instantiated once.

Verification
REQ-033 ALU op: ALUResult=120, RegDestSelected=16, RegWrite=1 -> next cycle OutValid=1, WB_Data=120, WB_RegDest=16, Stall never high.
REQ-034 Signed byte load at 0x00000103, MemRData=0x80AABBCC, ack after 3 cycles -> MemAddr=0x100, MemByteEn=1111, WB_Data=0xFFFFFF80, Stall high 3 cycles.
REQ-035 Half store at 0x00000102 of WriteData=0x00001234 -> MemWe=1, MemByteEn=1100, MemWData=0x12341234, WB_RegWrite=0.
REQ-036 Word load at 0x00000006 -> no MemReq, Misaligned pulses once, OutValid=1, WB_RegWrite=0.
REQ-037 Load with MemAck withheld -> after 16 WAIT_ACK cycles BusError=1, MemReq=0, OutValid=1 with WB_RegWrite=0; a late MemAck changes nothing.
REQ-038 Rst low mid-WAIT_ACK -> MemReq=0 and OutValid=0 immediately; after release the next ALU op completes normally.
